uart_tx_fifo: RTL

//  UART transmitter feeding the uart tx pad (io_pad_o[1]); transmit counterpart of the uart rx line on io_pad_i[0].

---
 rtl/uart_tx_fifo_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the core-side register block and the UART transmitter.
interface uart_tx_fifo_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding a start/8 data/[parity]/1-2 stop serialiser.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  uart_tx_fifo_if.slave                 bus,
  output logic                          tx_o,
  output logic                          tx_oe,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, empty, push, pop;
  logic [7:0]    head;

  state_t        state, state_n;
  logic [DIV_W-1:0] timer, timer_n, div_q, div_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_en_q, par_en_n, par_odd_q, par_odd_n, stop2_q, stop2_n;
  logic          tx_q, tx_n;
  logic          bit_end, load;

  assign full         = (level == FULL_LVL);
  assign empty        = (level == '0);
  assign push         = bus.tx_valid && !full;
  assign head         = mem[rd_ptr];
  assign bus.tx_ready = !full;
  assign fifo_level   = level;
  assign tx_o         = tx_q;
  assign tx_oe        = 1'b1;
  assign busy         = (state != IDLE) || !empty;
  assign bit_end      = (timer == '0);
  assign pop          = load;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      div_q     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      div_q     <= div_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      par_en_q  <= par_en_n;
      par_odd_q <= par_odd_n;
      stop2_q   <= stop2_n;
      tx_q      <= tx_n;
    end
  end

  // tx_n is the level for the bit beginning at this edge, so the line is registered.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    div_n     = div_q;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    par_en_n  = par_en_q;
    par_odd_n = par_odd_q;
    stop2_n   = stop2_q;
    tx_n      = tx_q;
    load      = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        load = !empty;
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n   = '0;
        tx_n    = shreg[0];
      end
      DATA: if (bit_end) begin
        if (bit_cnt == 3'd7) begin
          bit_n = '0;
          if (par_en_q) begin
            state_n = PARITY;
            tx_n    = ^shreg ^ par_odd_q;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_n = bit_cnt + 3'd1;
          tx_n  = shreg[bit_cnt + 3'd1];
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (stop2_q && bit_cnt == 3'd0) bit_n = 3'd1;
        else if (!empty)                load  = 1'b1;
        else                            state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE) timer_n = bit_end ? div_q : timer - 1'b1;

    // Pop from IDLE or straight out of the last stop bit; frame config is captured here.
    if (load) begin
      state_n   = START;
      shreg_n   = head;
      div_n     = baud_div;
      timer_n   = baud_div;
      par_en_n  = parity_en;
      par_odd_n = parity_odd;
      stop2_n   = stop2;
      tx_n      = 1'b0;
    end
  end

endmodule
